// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : pipe_stall_ctrl
// Description : Pipeline stall/flush sequencing for the 5-stage MIPS core:
//               load-use and HI/LO hazards, MULT/DIV busy sequencing, and a
//               saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// =============================================================================
module pipe_stall_ctrl #(
  parameter int MDIV_CYCLES = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_reg1_read_i,
  input  logic [4:0]        id_reg1_addr_i,
  input  logic              id_reg2_read_i,
  input  logic [4:0]        id_reg2_addr_i,
  input  logic              id_hilo_use_i,
  input  logic              ex_is_load_i,
  input  logic              ex_wreg_i,
  input  logic [4:0]        ex_wd_i,
  input  logic              ex_mdiv_start_i,
  input  logic              flush_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              mdiv_busy_o,
  output logic              mdiv_done_o,
  output logic [PERF_W-1:0] perf_stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_load     = CNT_W'(MDIV_CYCLES - 1);
  localparam logic [5:0]       c_stall_none   = 6'b000000;
  localparam logic [5:0]       c_stall_mdiv   = 6'b001111;
  localparam logic [5:0]       c_stall_bubble = 6'b000111;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PERF_W-1:0]  r_perf;

  logic               w_reg1_hit;
  logic               w_reg2_hit;
  logic               w_load_use;
  logic               w_hilo_haz;
  logic               w_mdiv_hold;
  logic [5:0]         w_stall;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign w_reg1_hit = id_reg1_read_i && (id_reg1_addr_i == ex_wd_i);
  assign w_reg2_hit = id_reg2_read_i && (id_reg2_addr_i == ex_wd_i);
  assign w_load_use = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
                      (w_reg1_hit || w_reg2_hit);
  assign w_hilo_haz = id_hilo_use_i && (r_state != ST_IDLE);

  // The start cycle itself stalls too, so EX holds the MULT/DIV in place.
  assign w_mdiv_hold = (r_state == ST_BUSY) ||
                       ((r_state == ST_IDLE) && ex_mdiv_start_i);

  always_comb begin
    w_stall = c_stall_none;
    if (flush_i) begin
      w_stall = c_stall_none;
    end else if (w_mdiv_hold) begin
      w_stall = c_stall_mdiv;
    end else if (w_load_use || w_hilo_haz) begin
      w_stall = c_stall_bubble;
    end
  end

  // ---------------------------------------------------------------------------
  // MULT/DIV sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (ex_mdiv_start_i && !flush_i) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = c_cnt_load;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        // The finishing instruction is still in EX, so its start is ignored.
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else if ((w_stall != c_stall_none) && (r_perf != {PERF_W{1'b1}})) begin
      r_perf <= r_perf + PERF_W'(1);
    end
  end

  assign stall_o          = w_stall;
  assign flush_o          = flush_i;
  assign mdiv_busy_o      = (r_state == ST_BUSY);
  assign mdiv_done_o      = (r_state == ST_DONE);
  assign perf_stall_cnt_o = r_perf;

endmodule
`default_nettype wire
